writeback_opnds: RTL



---
 rtl/writeback_opnds_pkg.sv | 34 +++
 rtl/writeback_opnds_if.sv | 39 +++
 rtl/writeback_opnds_hint_match.sv | 33 +++
 rtl/writeback_opnds.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/writeback_opnds_pkg.sv
// Shared constants for the operand writeback block: destination kinds,
// FSM state encoding and register-file byte-enable masks.
package writeback_opnds_pkg;

  localparam logic [1:0] OPND_DEST_NONE     = 2'b00;
  localparam logic [1:0] OPND_DEST_REG_1HOT = 2'b01;
  localparam logic [1:0] OPND_DEST_MEM_1HOT = 2'b10;

  localparam logic [3:0] BYTE_MASK_32 = 4'b1111;
  localparam logic [3:0] BYTE_MASK_16 = 4'b0011;
  localparam logic [3:0] BYTE_MASK_B0 = 4'b0001;
  localparam logic [3:0] BYTE_MASK_B1 = 4'b0010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WB0   = 3'd1,
    WB1   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } wb_state_t;

  // A single-byte access wins over the 16-bit operand prefix.
  function automatic logic [3:0] wb_byte_mask(input logic one_byte, input logic op16,
                                              input logic hi_byte);
    if (one_byte) return hi_byte ? BYTE_MASK_B1 : BYTE_MASK_B0;
    if (op16) return BYTE_MASK_16;
    return BYTE_MASK_32;
  endfunction

  function automatic logic [31:0] wb_bit_mask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/writeback_opnds_if.sv
// Request, write-hint and register-file write signals of writeback_opnds.
interface writeback_opnds_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        dest0_kind;
  logic [1:0]        dest1_kind;
  logic [ADDR_W-1:0] dest0_sel;
  logic [ADDR_W-1:0] dest1_sel;
  logic [ADDR_W-1:0] res0;
  logic [ADDR_W-1:0] res1;
  logic              reg_1byte;
  logic              prefix_operand_16bit;
  logic              hint1_is_write;
  logic              hint2_is_write;
  logic [ADDR_W-1:0] hint1_address;
  logic [ADDR_W-1:0] hint2_address;
  logic [ADDR_W-1:0] hint1_data;
  logic [ADDR_W-1:0] hint2_data;
  logic              reg_we;
  logic [2:0]        reg_wsel;
  logic [ADDR_W-1:0] reg_wdata;
  logic [3:0]        reg_wmask;
  logic              done;
  logic              fault;

  modport master (
    output in_valid, dest0_kind, dest1_kind, dest0_sel, dest1_sel, res0, res1,
           reg_1byte, prefix_operand_16bit, hint1_is_write, hint2_is_write,
           hint1_address, hint2_address, hint1_data, hint2_data,
    input  in_ready, reg_we, reg_wsel, reg_wdata, reg_wmask, done, fault
  );

  modport slave (
    input  in_valid, dest0_kind, dest1_kind, dest0_sel, dest1_sel, res0, res1,
           reg_1byte, prefix_operand_16bit, hint1_is_write, hint2_is_write,
           hint1_address, hint2_address, hint1_data, hint2_data,
    output in_ready, reg_we, reg_wsel, reg_wdata, reg_wmask, done, fault
  );
endinterface

// File: rtl/writeback_opnds_hint_match.sv
// Matches one memory destination against the two write hints; the first hint has
// priority and a hint already consumed by an earlier destination is skipped.
module wb_hint_match
  import writeback_opnds_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] result,
  input  logic [3:0]        mask,
  input  logic              hint1_write,
  input  logic [ADDR_W-1:0] hint1_addr,
  input  logic [ADDR_W-1:0] hint1_data,
  input  logic              hint2_write,
  input  logic [ADDR_W-1:0] hint2_addr,
  input  logic [ADDR_W-1:0] hint2_data,
  input  logic              used1,
  input  logic              used2,
  output logic              hit1,
  output logic              hit2,
  output logic              matched
);

  logic [ADDR_W-1:0] bits;

  assign bits    = wb_bit_mask(mask);
  assign hit1    = hint1_write && !used1 && (hint1_addr == addr) &&
                   (((hint1_data ^ result) & bits) == '0);
  assign hit2    = !hit1 && hint2_write && !used2 && (hint2_addr == addr) &&
                   (((hint2_data ^ result) & bits) == '0);
  assign matched = hit1 || hit2;

endmodule

// File: rtl/writeback_opnds.sv
// Two-destination operand writeback FSM. Define WRITEBACK_HINT_CHECK_EN to check
// memory destinations against the write hints; otherwise every MEM write is accepted.
module writeback_opnds
  import writeback_opnds_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  writeback_opnds_if.slave  bus
);

  wb_state_t state, state_n;
  logic      used1, used2, take1, take2, accept;

  logic [1:0]        dest0_kind_p0, dest1_kind_p0;
  logic [ADDR_W-1:0] dest0_sel_p0, dest1_sel_p0, res0_p0, res1_p0;
  logic              one_byte_p0, op16_p0;
  logic              h1_we_p0, h2_we_p0;
  logic [ADDR_W-1:0] h1_addr_p0, h2_addr_p0, h1_data_p0, h2_data_p0;

  logic [1:0]        cur_kind;
  logic [ADDR_W-1:0] cur_sel, cur_res;
  logic [3:0]        reg_mask, mem_mask;
  logic              mem_ok, hit1, hit2;

  logic              in_ready_c, done_c, reg_we_c;
  logic [2:0]        reg_wsel_c;
  logic [ADDR_W-1:0] reg_wdata_c;
  logic [3:0]        reg_wmask_c;

  assign accept = (state == IDLE) && bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      used1 <= 1'b0;
      used2 <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        used1 <= 1'b0;
        used2 <= 1'b0;
      end else begin
        if (take1) used1 <= 1'b1;
        if (take2) used2 <= 1'b1;
      end
    end
  end

  // p0: request and hints captured on accept, held for the whole operation
  always_ff @(posedge clk) begin
    if (accept) begin
      dest0_kind_p0 <= bus.dest0_kind;
      dest1_kind_p0 <= bus.dest1_kind;
      dest0_sel_p0  <= bus.dest0_sel;
      dest1_sel_p0  <= bus.dest1_sel;
      res0_p0       <= bus.res0;
      res1_p0       <= bus.res1;
      one_byte_p0   <= bus.reg_1byte;
      op16_p0       <= bus.prefix_operand_16bit;
      h1_we_p0      <= bus.hint1_is_write;
      h2_we_p0      <= bus.hint2_is_write;
      h1_addr_p0    <= bus.hint1_address;
      h2_addr_p0    <= bus.hint2_address;
      h1_data_p0    <= bus.hint1_data;
      h2_data_p0    <= bus.hint2_data;
    end
  end

  always_comb begin
    cur_kind = (state == WB1) ? dest1_kind_p0 : dest0_kind_p0;
    cur_sel  = (state == WB1) ? dest1_sel_p0  : dest0_sel_p0;
    cur_res  = (state == WB1) ? res1_p0       : res0_p0;
    reg_mask = wb_byte_mask(one_byte_p0, op16_p0, cur_sel[2]);
    mem_mask = wb_byte_mask(one_byte_p0, op16_p0, 1'b0);
  end

`ifdef WRITEBACK_HINT_CHECK_EN
  logic hit1_d0, hit2_d0, ok_d0, hit1_d1, hit2_d1, ok_d1;

  wb_hint_match #(.ADDR_W(ADDR_W)) u_match_wb0 (
    .addr(dest0_sel_p0), .result(res0_p0), .mask(mem_mask),
    .hint1_write(h1_we_p0), .hint1_addr(h1_addr_p0), .hint1_data(h1_data_p0),
    .hint2_write(h2_we_p0), .hint2_addr(h2_addr_p0), .hint2_data(h2_data_p0),
    .used1(used1), .used2(used2), .hit1(hit1_d0), .hit2(hit2_d0), .matched(ok_d0)
  );

  wb_hint_match #(.ADDR_W(ADDR_W)) u_match_wb1 (
    .addr(dest1_sel_p0), .result(res1_p0), .mask(mem_mask),
    .hint1_write(h1_we_p0), .hint1_addr(h1_addr_p0), .hint1_data(h1_data_p0),
    .hint2_write(h2_we_p0), .hint2_addr(h2_addr_p0), .hint2_data(h2_data_p0),
    .used1(used1), .used2(used2), .hit1(hit1_d1), .hit2(hit2_d1), .matched(ok_d1)
  );

  assign mem_ok = (state == WB1) ? ok_d1   : ok_d0;
  assign hit1   = (state == WB1) ? hit1_d1 : hit1_d0;
  assign hit2   = (state == WB1) ? hit2_d1 : hit2_d0;
`else
  logic unused_hint_path;

  assign mem_ok = 1'b1;
  assign hit1   = 1'b0;
  assign hit2   = 1'b0;
  assign unused_hint_path = ^{h1_we_p0, h2_we_p0, h1_addr_p0, h2_addr_p0, h1_data_p0,
                              h2_data_p0, used1, used2, mem_mask, cur_sel};
`endif

  always_comb begin
    state_n     = state;
    in_ready_c  = 1'b0;
    done_c      = 1'b0;
    reg_we_c    = 1'b0;
    reg_wsel_c  = '0;
    reg_wdata_c = '0;
    reg_wmask_c = '0;
    take1       = 1'b0;
    take2       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_n = WB0;
      end
      WB0, WB1: begin
        state_n = (state == WB0) ? WB1 : DONE;
        case (cur_kind)
          OPND_DEST_NONE: ;
          OPND_DEST_REG_1HOT: begin
            reg_we_c    = 1'b1;
            reg_wmask_c = reg_mask;
            reg_wsel_c  = one_byte_p0 ? {1'b0, cur_sel[1:0]} : cur_sel[2:0];
            // High-byte registers (sel 4-7) take the result in bits [15:8]
            if (reg_mask == BYTE_MASK_B1)
              reg_wdata_c = {{(ADDR_W-16){1'b0}}, cur_res[7:0], 8'h00};
            else
              reg_wdata_c = cur_res & wb_bit_mask(reg_mask);
          end
          OPND_DEST_MEM_1HOT: begin
            if (mem_ok) begin
              take1 = hit1;
              take2 = hit2;
            end else begin
              state_n = FAULT;
            end
          end
          default: state_n = FAULT;
        endcase
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      FAULT: ;
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.done      = done_c;
  assign bus.fault     = (state == FAULT);
  assign bus.reg_we    = reg_we_c;
  assign bus.reg_wsel  = reg_wsel_c;
  assign bus.reg_wdata = reg_wdata_c;
  assign bus.reg_wmask = reg_wmask_c;

endmodule
